dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data RAM between the CPU data port and the VGA board-scan reader, which fetches board-state words for display.
- The CPU owns the port by default. The video reader takes idle CPU cycles.
- A starvation guard forces one video slot after STARVE_LIMIT lost cycles, and stalls the CPU for that cycle.
- Sits between processor/VGA logic and RAM inside the top-level wrapper.

Parameters:
- ADDR_W, 12, RAM word-address width.
- DATA_W, 32, RAM data width.
- STARVE_LIMIT, 8, consecutive denied video cycles before a forced grant; legal range 1..255.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_en  in  1  CPU performs a dmem access (load or store) this cycle.
- cpu_wren  in  1  CPU store enable; ignored unless cpu_en=1.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_data  in  DATA_W  CPU store data.
- cpu_q  out  DATA_W  CPU load data; equals ram_dataOut.
- cpu_stall  out  1  CPU must hold its access this cycle and retry it.
- vid_req  in  1  video read request; held with a stable vid_addr until vid_ack.
- vid_addr  in  ADDR_W  video word address.
- vid_ack  out  1  one-cycle pulse; the video request is accepted this cycle.
- vid_q  out  DATA_W  video read data.
- vid_valid  out  1  vid_q is valid; asserted exactly one cycle after vid_ack.
- ram_wEn  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_dataIn  out  DATA_W  RAM write data.
- ram_dataOut  in  DATA_W  RAM read data; registered, 1-cycle latency.

Behaviour:
- State registers:
  - wait_cnt (8 bit).
  - vid_valid_r.
  - vid_q_r (optional; vid_q may be a direct copy of ram_dataOut).
- Reset (synchronous, reset=1 at an edge):
  - wait_cnt=0, vid_valid=0.
  - During reset, vid_ack=0, cpu_stall=0, ram_wEn=0, ram_addr=0, ram_dataIn=0.
  - vid_q holds 0 until the first valid read.
- Grant decision (combinational, every cycle):
  - grant_vid = vid_req & (~cpu_en | (wait_cnt == STARVE_LIMIT)).
  - vid_ack = grant_vid.
  - cpu_stall = grant_vid & cpu_en.
- Port mux:
  - If grant_vid: ram_addr=vid_addr, ram_wEn=0. The video port is read-only, so it never writes.
  - Otherwise: ram_addr=cpu_addr, ram_dataIn=cpu_data, ram_wEn=cpu_en & cpu_wren.
  - ram_dataIn = cpu_data always; it is harmless because wEn=0 during video slots.
- Starvation counter, per edge:
  - reset, or vid_req=0, or grant_vid → wait_cnt=0.
  - Otherwise (vid_req=1 and denied) → wait_cnt+1, saturating at STARVE_LIMIT.
- Read return:
  - vid_valid_r <= grant_vid. Video data for an ack at cycle N appears at cycle N+1.
  - cpu_q = ram_dataOut unconditionally. A CPU load accepted at cycle N returns at N+1, even if video is granted at N+1.
- Back-to-back:
  - Video may be granted every cycle while cpu_en=0.
  - After a forced grant, the counter restarts from 0, so the CPU loses at most 1 cycle in every STARVE_LIMIT+1.
- Simultaneous events:
  - cpu_en store and forced video grant in the same cycle: the store is not performed; cpu_stall=1; the CPU retries next cycle.
  - vid_req dropped before ack: no grant, counter clears, no vid_valid.
- Reset mid-operation:
  - A pending vid_valid (ack in the reset cycle) is cancelled: vid_valid=0 the next cycle.
  - Any access presented during reset is dropped.
- Addresses pass through unmodified. There is no wrap or bounds logic; the RAM decodes ADDR_W bits.

Test Plan:
1. Reset, then cpu_en=1, cpu_wren=1, addr 0x010, data 0xDEADBEEF; next cycle load 0x010 → ram_wEn=1 only in the store cycle; cpu_q=0xDEADBEEF one cycle after the load; cpu_stall=0 throughout.
2. CPU idle, vid_req=1, vid_addr=0x100 (preloaded 0x00000005) → vid_ack in the same cycle, vid_valid=1 and vid_q=0x00000005 the next cycle; ram_wEn=0.
3. cpu_en=1 continuously, vid_req=1 at addr 0x200, STARVE_LIMIT=8 → ack denied for 8 cycles (wait_cnt 0→8); cycle 9: vid_ack=1, cpu_stall=1, ram_addr=0x200; then the counter returns to 0 and the pattern repeats every 9 cycles.
4. Forced grant coincides with a CPU store to 0x020 of 0x12345678 → RAM unchanged that cycle; CPU holds the store; the next cycle ram_wEn=1 and a readback gives 0x12345678.
5. vid_req raised for 3 denied cycles then dropped → wait_cnt back to 0; no vid_ack, no vid_valid.
6. Reset asserted in the same cycle as vid_ack → vid_valid=0 the next cycle, wait_cnt=0, and the arbiter operates normally after reset deasserts.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - single-port data RAM arbiter between the CPU data port and the VGA board-scan reader
module dmem_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_en,
    input  logic              cpu_wren,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    output logic [DATA_W-1:0] cpu_q,
    output logic              cpu_stall,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic [DATA_W-1:0] vid_q,
    output logic              vid_valid,
    output logic              ram_wEn,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_dataIn,
    input  logic [DATA_W-1:0] ram_dataOut
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [7:0]        wait_cnt_q, wait_cnt_d;
    logic              vid_valid_q, vid_valid_d;
    logic [DATA_W-1:0] vid_hold_q, vid_hold_d;
    logic              grant_vid;

    always_comb begin
        grant_vid   = !reset && vid_req && (!cpu_en || (wait_cnt_q == LIMIT));
        vid_ack     = grant_vid;
        cpu_stall   = grant_vid && cpu_en;

        ram_wEn     = 1'b0;
        ram_addr    = '0;
        ram_dataIn  = '0;
        if (!reset) begin
            ram_dataIn = cpu_data;
            if (grant_vid) begin
                ram_addr = vid_addr;
            end else begin
                ram_addr = cpu_addr;
                ram_wEn  = cpu_en && cpu_wren;
            end
        end

        wait_cnt_d = wait_cnt_q;
        if (!vid_req || grant_vid) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q < LIMIT) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end

        vid_valid_d = grant_vid;
        // The RAM output only carries video data for one cycle; keep a copy so vid_q stays stable afterwards.
        vid_hold_d  = vid_valid_q ? ram_dataOut : vid_hold_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt_q  <= '0;
            vid_valid_q <= 1'b0;
            vid_hold_q  <= '0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            vid_valid_q <= vid_valid_d;
            vid_hold_q  <= vid_hold_d;
        end
    end

    assign vid_valid = vid_valid_q;
    assign vid_q     = vid_valid_q ? ram_dataOut : vid_hold_q;
    assign cpu_q     = ram_dataOut;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized and directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int LIMIT  = 8;

    logic              clock = 1'b0;
    logic              reset;
    logic              cpu_en, cpu_wren;
    logic [ADDR_W-1:0] cpu_addr, vid_addr, ram_addr;
    logic [DATA_W-1:0] cpu_data, cpu_q, vid_q, ram_dataIn, ram_dataOut;
    logic              cpu_stall, vid_req, vid_ack, vid_valid, ram_wEn;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)) dut (
        .clock(clock), .reset(reset),
        .cpu_en(cpu_en), .cpu_wren(cpu_wren), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .cpu_q(cpu_q), .cpu_stall(cpu_stall),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_q(vid_q), .vid_valid(vid_valid),
        .ram_wEn(ram_wEn), .ram_addr(ram_addr), .ram_dataIn(ram_dataIn), .ram_dataOut(ram_dataOut)
    );

    always #5 clock = ~clock;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clock) begin
        if (ram_wEn) mem[ram_addr] <= ram_dataIn;
        ram_dataOut <= mem[ram_addr];
    end

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];
    int                denied;
    logic              m_vv;
    logic [DATA_W-1:0] m_rd, m_hold;
    logic              m_g, m_wen;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_din;
    logic              chk_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sample();
        @(negedge clock);
        m_g    = !reset && vid_req && (!cpu_en || denied >= LIMIT);
        m_wen  = !reset && !m_g && cpu_en && cpu_wren;
        m_addr = reset ? '0 : (m_g ? vid_addr : cpu_addr);
        m_din  = reset ? '0 : cpu_data;
        chk("vid_ack", 64'(vid_ack), 64'(m_g));
        chk("cpu_stall", 64'(cpu_stall), 64'(m_g && cpu_en));
        chk("ram_wEn", 64'(ram_wEn), 64'(m_wen));
        chk("ram_addr", 64'(ram_addr), 64'(m_addr));
        chk("ram_dataIn", 64'(ram_dataIn), 64'(m_din));
        chk("vid_valid", 64'(vid_valid), 64'(m_vv));
        if (chk_data) chk("cpu_q", 64'(cpu_q), 64'(m_rd));
        if (chk_data || !m_vv) chk("vid_q", 64'(vid_q), 64'(m_vv ? m_rd : m_hold));
    endtask

    task automatic advance();
        logic [DATA_W-1:0] nrd;
        @(posedge clock);
        m_hold = reset ? '0 : (m_vv ? m_rd : m_hold);
        nrd = ref_mem[m_addr];
        if (m_wen) ref_mem[m_addr] = m_din;
        m_rd = nrd;
        m_vv = m_g;
        if (reset || !vid_req || m_g) denied = 0;
        else if (denied < LIMIT) denied = denied + 1;
        #1;
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    task automatic drive(input logic en, input logic wr, input int a, input logic [31:0] d,
                         input logic vr, input int va);
        cpu_en = en; cpu_wren = wr; cpu_addr = ADDR_W'(a); cpu_data = d;
        vid_req = vr; vid_addr = ADDR_W'(va);
    endtask

    // CPU loads continuously with a held video request: ack only on the ninth cycle.
    task automatic starve_pattern(input string name, input int va);
        for (int i = 0; i < LIMIT + 1; i++) begin
            drive(1'b1, 1'b0, 'h030, 32'h0, 1'b1, va);
            sample();
            chk({name, "_ack"}, 64'(vid_ack), 64'(i == LIMIT));
            if (i == LIMIT) begin
                chk({name, "_stall"}, 64'(cpu_stall), 64'd1);
                chk({name, "_addr"}, 64'(ram_addr), 64'(va));
            end
            advance();
        end
    endtask

    initial begin
        chk_data = 1'b0;
        denied = 0; m_vv = 1'b0; m_hold = '0; m_rd = '0;
        // Reset with a store presented: it must be dropped
        reset = 1'b1;
        drive(1'b1, 1'b1, 'h003, 32'hFFFF_FFFF, 1'b1, 'h004);
        @(posedge clock); #1;
        sample();
        chk("rst_wEn", 64'(ram_wEn), 64'd0);
        chk("rst_ack", 64'(vid_ack), 64'd0);
        chk("rst_vid_q", 64'(vid_q), 64'd0);
        advance();
        reset = 1'b0;

        // Preload the address pool through the CPU port
        for (int a = 0; a < 64; a++) begin
            drive(1'b1, 1'b1, a, 32'hA500_0000 | 32'(a * 1001), 1'b0, 0);
            tick();
        end
        drive(1'b1, 1'b1, 'h100, 32'h0000_0005, 1'b0, 0); tick();
        drive(1'b1, 1'b1, 'h200, 32'hC0DE_0200, 1'b0, 0); tick();
        drive(1'b0, 1'b0, 0, 32'h0, 1'b0, 0); tick();
        chk_data = 1'b1;

        // 1: store then load
        drive(1'b1, 1'b1, 'h010, 32'hDEAD_BEEF, 1'b0, 0);
        sample(); chk("t1_wEn_store", 64'(ram_wEn), 64'd1); advance();
        drive(1'b1, 1'b0, 'h010, 32'h0, 1'b0, 0);
        sample(); chk("t1_wEn_load", 64'(ram_wEn), 64'd0); advance();
        drive(1'b0, 1'b0, 0, 32'h0, 1'b0, 0);
        sample(); chk("t1_cpu_q", 64'(cpu_q), 64'hDEAD_BEEF); chk("t1_stall", 64'(cpu_stall), 64'd0); advance();

        // 2: video read while CPU idle
        drive(1'b0, 1'b0, 0, 32'h0, 1'b1, 'h100);
        sample(); chk("t2_ack", 64'(vid_ack), 64'd1); chk("t2_wEn", 64'(ram_wEn), 64'd0); advance();
        drive(1'b0, 1'b0, 0, 32'h0, 1'b0, 0);
        sample(); chk("t2_valid", 64'(vid_valid), 64'd1); chk("t2_vid_q", 64'(vid_q), 64'h5); advance();
        sample(); chk("t2_valid_drop", 64'(vid_valid), 64'd0); chk("t2_vid_q_hold", 64'(vid_q), 64'h5); advance();

        // 3: starvation guard, repeating every LIMIT+1 cycles
        starve_pattern("t3a", 'h200);
        starve_pattern("t3b", 'h200);
        drive(1'b0, 1'b0, 0, 32'h0, 1'b0, 0); tick();

        // 4: forced grant collides with a store
        for (int i = 0; i < LIMIT; i++) begin
            drive(1'b1, 1'b0, 'h030, 32'h0, 1'b1, 'h040); tick();
        end
        drive(1'b1, 1'b1, 'h020, 32'h1234_5678, 1'b1, 'h040);
        sample(); chk("t4_stall", 64'(cpu_stall), 64'd1); chk("t4_wEn_blocked", 64'(ram_wEn), 64'd0); advance();
        drive(1'b1, 1'b1, 'h020, 32'h1234_5678, 1'b0, 0);
        sample(); chk("t4_wEn_retry", 64'(ram_wEn), 64'd1); advance();
        drive(1'b1, 1'b0, 'h020, 32'h0, 1'b0, 0); tick();
        drive(1'b0, 1'b0, 0, 32'h0, 1'b0, 0);
        sample(); chk("t4_readback", 64'(cpu_q), 64'h1234_5678); advance();

        // 5: request withdrawn after three denials clears the counter
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 'h030, 32'h0, 1'b1, 'h050);
            sample(); chk("t5_no_ack", 64'(vid_ack), 64'd0); advance();
        end
        drive(1'b1, 1'b0, 'h030, 32'h0, 1'b0, 0);
        sample(); chk("t5_no_valid", 64'(vid_valid), 64'd0); advance();
        starve_pattern("t5", 'h050);
        drive(1'b0, 1'b0, 0, 32'h0, 1'b0, 0); tick();

        // 6: reset mid-starvation with an otherwise grantable request
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 'h030, 32'h0, 1'b1, 'h060); tick();
        end
        reset = 1'b1;
        drive(1'b0, 1'b0, 0, 32'h0, 1'b1, 'h060);
        sample(); chk("t6_ack_in_reset", 64'(vid_ack), 64'd0); chk("t6_addr_in_reset", 64'(ram_addr), 64'd0); advance();
        reset = 1'b0;
        drive(1'b0, 1'b0, 0, 32'h0, 1'b0, 0);
        sample(); chk("t6_valid_after", 64'(vid_valid), 64'd0); advance();
        starve_pattern("t6", 'h060);

        // Randomized traffic against the model
        begin
            logic retry;
            retry = 1'b0;
            drive(1'b0, 1'b0, 0, 32'h0, 1'b0, 0);
            for (int i = 0; i < 4000; i++) begin
                int dens;
                dens = (i / 500) % 4;
                if (!retry) begin
                    cpu_en   = ($urandom_range(0, 3) < dens + 1);
                    cpu_wren = $urandom_range(0, 2) == 0;
                    cpu_addr = ADDR_W'($urandom_range(0, 63));
                    cpu_data = $urandom;
                end
                if (!vid_req || m_vv) begin
                    vid_req  = $urandom_range(0, 2) != 0;
                    vid_addr = ADDR_W'($urandom_range(0, 63));
                end else if ($urandom_range(0, 29) == 0) begin
                    vid_req = 1'b0;
                end
                reset = ($urandom_range(0, 199) == 0);
                sample();
                retry = cpu_stall;
                advance();
                if (m_vv && vid_req) vid_req = 1'b0;
            end
            reset = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
